fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/core_pkg.sv | 29 ++
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/fetch_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// core_pkg -- shared definitions for the instruction-fetch front end.
//   fetch_state_e : fetch sequencer states (FETCH / WAIT / DRAIN)
//   fetch_entry_t : one instruction-buffer entry {pc, inst}
//   XLEN, INST_W  : address and instruction widths
//   DEFAULT_RESET_PC : default first fetch address after reset
package core_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,  // may issue a request
    S_WAIT  = 2'd1,  // one request granted, response pending
    S_DRAIN = 2'd2   // discard one stale response
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Force an address onto a 32-bit word boundary.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo -- two-entry in-order {pc, inst} buffer between the memory
// response and the decode stage. The head entry comes straight from storage
// registers, so there is no combinational path from push_data to head.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset (empties, clears entries)
//   push         : write push_data at the tail (ignored when full or flushing)
//   push_data    : entry to write
//   pop          : retire the head entry (ignored when empty or flushing)
//   flush        : empty the buffer; wins over push and pop
//   full, empty  : occupancy flags
//   head         : current head entry (valid when !empty)
module fetch_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  fetch_entry_t mem_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign full    = (count_q == 2'(DEPTH));
  assign empty   = (count_q == 2'd0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_q ^ do_pop;
      wr_ptr_q <= wr_ptr_q ^ do_push;
      // Simultaneous push and pop leaves the count unchanged.
      count_q  <= count_q + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch sequencer with a two-entry buffer.
// Issues one word-aligned read at a time, buffers responses with their PC
// and presents them in order to decode. A redirect flushes everything and
// restarts fetch at the target; a response still in flight at that moment
// is drained and dropped.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   imem_req/addr     : read request and word address (held until imem_gnt)
//   imem_gnt          : memory accepted the request this cycle
//   imem_rvalid/rdata : read response
//   redirect/_pc      : redirect pulse and target from execute
//   out_valid/ready   : decode handshake
//   out_inst/out_pc   : presented instruction word and its address
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int              BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [XLEN-1:0]   out_pc
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] issued_pc_q;
  logic            run_q;

  logic            buf_full;
  logic            buf_empty;
  logic            buf_push;
  logic            buf_pop;
  fetch_entry_t    buf_head;
  fetch_entry_t    buf_wdata;
  logic            gnt_fire;

  // In FETCH nothing is outstanding, so "buffer not full" is the same as
  // occupancy plus outstanding below two. run_q keeps the request low
  // through the reset cycle itself. A redirect withdraws the request so that
  // no grant can race with the re-address.
  assign imem_req  = run_q && (state_q == S_FETCH) && !buf_full && !redirect;
  assign imem_addr = pc_q;
  assign gnt_fire  = imem_req && imem_gnt;

  assign buf_push  = (state_q == S_WAIT) && imem_rvalid && !redirect;
  assign buf_pop   = out_valid && out_ready && !redirect;
  assign buf_wdata = '{pc: issued_pc_q, inst: imem_rdata};

  assign out_valid = !buf_empty;
  assign out_inst  = buf_head.inst;
  assign out_pc    = buf_head.pc;

  // PC wraps naturally from FFFF_FFFC to 0 through the 32-bit add.
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = align_word(redirect_pc);
    end else if (gnt_fire) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      pc_q        <= align_word(RESET_PC);
      issued_pc_q <= '0;
      run_q       <= 1'b0;
    end else begin
      run_q <= 1'b1;
      pc_q  <= pc_d;
      case (state_q)
        S_FETCH: begin
          if (gnt_fire) begin
            state_q     <= S_WAIT;
            issued_pc_q <= pc_q;
          end
        end
        S_WAIT: begin
          // A response arriving with a redirect is simply not pushed.
          if (imem_rvalid) begin
            state_q <= S_FETCH;
          end else if (redirect) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // The stale response ends the drain even when a further redirect
          // arrives in the same cycle; nothing else is in flight to wait for.
          if (imem_rvalid) begin
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH(BUF_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (buf_push),
    .push_data(buf_wdata),
    .pop      (buf_pop),
    .flush    (redirect),
    .full     (buf_full),
    .empty    (buf_empty),
    .head     (buf_head)
  );

endmodule
